sync_fifo_prog: RTL

SYNC_FIFO_PROG -- requirements
Module: sync_fifo_prog

---
 rtl/sync_fifo_prog_if.sv | 29 ++
 rtl/sync_fifo_prog.sv | 115 +++++++++++
 2 files changed

// File: rtl/sync_fifo_prog_if.sv
// Handshake/data bundle for sync_fifo_prog: the producer/consumer side drives
// requests via master; the FIFO drives data and status flags via slave.
interface sync_fifo_prog_if #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8
);
  logic                          flush;
  logic                          wr_en;
  logic [FIFO_WIDTH-1:0]         data_in;
  logic                          rd_en;
  logic [FIFO_WIDTH-1:0]         data_out;
  logic                          valid_out;
  logic                          full, empty, almostfull, almostempty;
  logic                          prog_full, prog_empty;
  logic                          wr_ack, overflow, underflow;
  logic [$clog2(FIFO_DEPTH):0]   count;

  modport master (
    output flush, wr_en, data_in, rd_en,
    input  data_out, valid_out, full, empty, almostfull, almostempty,
           prog_full, prog_empty, wr_ack, overflow, underflow, count
  );

  modport slave (
    input  flush, wr_en, data_in, rd_en,
    output data_out, valid_out, full, empty, almostfull, almostempty,
           prog_full, prog_empty, wr_ack, overflow, underflow, count
  );
endinterface

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable thresholds, arbitrary depth and
// optional first-word-fall-through read port.
module sync_fifo_prog #(
  parameter int FIFO_WIDTH    = 16,
  parameter int FIFO_DEPTH    = 8,
  parameter int PROG_FULL_TH  = 6,
  parameter int PROG_EMPTY_TH = 2,
  parameter bit FWFT          = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  sync_fifo_prog_if.slave  bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  typedef logic [PW-1:0] ptr_t;

  logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
  ptr_t                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [FIFO_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_q, valid_d;
  logic                  wr_ack_q, wr_ack_d, ovf_q, ovf_d, udf_q, udf_d;
  logic                  full, empty, wr_acc, rd_acc;

  // Explicit compare-and-wrap so non-power-of-two depths work.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(FIFO_DEPTH - 1)) ? '0 : ptr_t'(p + 1'b1);
  endfunction

  assign full   = (count_q == CW'(FIFO_DEPTH));
  assign empty  = (count_q == '0);
  assign wr_acc = bus.wr_en && !bus.flush && !full;
  assign rd_acc = bus.rd_en && !bus.flush && !empty;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    wr_ack_d   = 1'b0;
    ovf_d      = 1'b0;
    udf_d      = 1'b0;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ack_d = wr_acc;
      ovf_d    = bus.wr_en && full;
      udf_d    = bus.rd_en && empty;
      if (wr_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (rd_acc) begin
        rd_ptr_d   = ptr_inc(rd_ptr_q);
        data_out_d = mem_q[rd_ptr_q];
        valid_d    = 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      wr_ack_q   <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      wr_ack_q   <= wr_ack_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= bus.data_in;
  end

  generate
    if (FWFT) begin : g_fwft
      // Gate to zero while empty so reset shows data_out=0.
      assign bus.data_out  = empty ? '0 : mem_q[rd_ptr_q];
      assign bus.valid_out = !empty;
    end else begin : g_reg
      assign bus.data_out  = data_out_q;
      assign bus.valid_out = valid_q;
    end
  endgenerate

  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.almostfull  = (count_q == CW'(FIFO_DEPTH - 1));
  assign bus.almostempty = (count_q == CW'(1));
  assign bus.prog_full   = (count_q >= CW'(PROG_FULL_TH));
  assign bus.prog_empty  = (count_q <= CW'(PROG_EMPTY_TH));
  assign bus.wr_ack      = wr_ack_q;
  assign bus.overflow    = ovf_q;
  assign bus.underflow   = udf_q;
  assign bus.count       = count_q;
endmodule
